frame_min_len_pad: RTL

//  Multi-channel minimum-frame-length enforcer for the qbu_tx path, placed between the MAC queues and the preemption/framing logic.

---
 rtl/qbu_tx_pkg.sv | 11 +
 rtl/frame_pad_ch.sv | 113 +++++++++++
 rtl/frame_min_len_pad.sv | 54 +++++
 3 files changed

// File: rtl/qbu_tx_pkg.sv
// qbu_tx_pkg: shared types and helpers for the qbu_tx minimum-length padding path
package qbu_tx_pkg;
  typedef enum logic [1:0] {IDLE, PASS, PAD} pad_state_t;
  localparam int MIN_LEN_DEFAULT = 46;
  function automatic logic [15:0] popcount_keep(input logic [63:0] keep);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 16'(keep[i]);
    return n;
  endfunction
endpackage

// File: rtl/frame_pad_ch.sv
// frame_pad_ch: one AXIS channel that zero-pads short frames up to MIN_LEN bytes
module frame_pad_ch
  import qbu_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MIN_LEN = MIN_LEN_DEFAULT,
  parameter bit PAD_EN = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [15:0]           i_user,
  input  logic [DATA_W/8-1:0]   i_keep,
  input  logic                  i_last,
  input  logic                  i_valid,
  input  logic [15:0]           i_type,
  output logic                  o_ready,
  output logic [DATA_W-1:0]     o_data,
  output logic [15:0]           o_user,
  output logic [DATA_W/8-1:0]   o_keep,
  output logic                  o_last,
  output logic                  o_valid,
  output logic [15:0]           o_type,
  input  logic                  i_ready,
  output logic                  o_pad_act
);
  localparam int BYTES = DATA_W / 8;
  localparam logic [16:0] MIN_L = 17'(MIN_LEN);
  localparam logic [16:0] BYTES_L = 17'(BYTES);
  pad_state_t state, state_n;
  logic [15:0] cnt, cnt_n, cap_user, cap_type, usr, typ;
  logic [16:0] sum, rem;
  logic [DATA_W-1:0] lane_mask, data_n;
  logic [BYTES-1:0] rem_keep, keep_n;
  logic acc, load, last_n, tail;
  assign o_ready = !i_rst && (!o_valid || i_ready) && state != PAD;
  assign acc = i_valid && o_ready;
  assign load = acc || (state == PAD && (!o_valid || i_ready));
  assign o_pad_act = state == PAD;
  assign usr = state == IDLE ? i_user : cap_user;
  assign typ = state == IDLE ? i_type : cap_type;
  assign sum = {1'b0, cnt} + {1'b0, popcount_keep(64'(i_keep))};
  assign rem = MIN_L - {1'b0, cnt};
  assign tail = rem <= BYTES_L;
  always_comb begin
    lane_mask = '0;
    rem_keep = '0;
    for (int i = 0; i < BYTES; i++) begin
      lane_mask[i*8 +: 8] = {8{i_keep[i]}};
      rem_keep[i] = 17'(i) < rem;
    end
  end
  // a short last beat and a pad beat share the same tail rule on the remaining byte count
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    data_n = i_data;
    keep_n = i_keep;
    last_n = i_last;
    if (state == PAD) begin
      data_n = '0;
      keep_n = tail ? rem_keep : '1;
      last_n = tail;
      if (load) begin
        state_n = tail ? IDLE : PAD;
        cnt_n = tail ? '0 : cnt + 16'(BYTES);
      end
    end else if (acc) begin
      if (!i_last) begin
        state_n = PASS;
        cnt_n = sum >= MIN_L ? 16'(MIN_LEN) : sum[15:0];
      end else if (!PAD_EN || sum >= MIN_L) begin
        state_n = IDLE;
        cnt_n = '0;
      end else begin
        data_n = i_data & lane_mask;
        keep_n = tail ? rem_keep : '1;
        last_n = tail;
        state_n = tail ? IDLE : PAD;
        cnt_n = tail ? '0 : cnt + 16'(BYTES);
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      cap_user <= '0;
      cap_type <= '0;
      o_data <= '0;
      o_user <= '0;
      o_keep <= '0;
      o_last <= 1'b0;
      o_valid <= 1'b0;
      o_type <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_valid <= load || (o_valid && !i_ready);
      if (acc && state == IDLE) begin
        cap_user <= i_user;
        cap_type <= i_type;
      end
      if (load) begin
        o_data <= data_n;
        o_keep <= keep_n;
        o_last <= last_n;
        o_type <= typ;
        o_user <= (PAD_EN && usr < 16'(MIN_LEN)) ? 16'(MIN_LEN) : usr;
      end
    end
  end
endmodule

// File: rtl/frame_min_len_pad.sv
// frame_min_len_pad: multi-channel minimum-frame-length enforcer for the qbu_tx path
module frame_min_len_pad
  import qbu_tx_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int MIN_LEN = MIN_LEN_DEFAULT,
  parameter logic [NUM_CH-1:0] PAD_EN = '1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_CH*DATA_W-1:0]       i_data,
  input  logic [NUM_CH*16-1:0]           i_user,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   i_keep,
  input  logic [NUM_CH-1:0]              i_last,
  input  logic [NUM_CH-1:0]              i_valid,
  input  logic [NUM_CH*16-1:0]           i_type,
  output logic [NUM_CH-1:0]              o_ready,
  output logic [NUM_CH*DATA_W-1:0]       o_data,
  output logic [NUM_CH*16-1:0]           o_user,
  output logic [NUM_CH*(DATA_W/8)-1:0]   o_keep,
  output logic [NUM_CH-1:0]              o_last,
  output logic [NUM_CH-1:0]              o_valid,
  output logic [NUM_CH*16-1:0]           o_type,
  input  logic [NUM_CH-1:0]              i_ready,
  output logic [NUM_CH-1:0]              o_pad_act
);
  localparam int BYTES = DATA_W / 8;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    frame_pad_ch #(
      .DATA_W (DATA_W),
      .MIN_LEN(MIN_LEN),
      .PAD_EN (PAD_EN[c])
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_data   (i_data[c*DATA_W +: DATA_W]),
      .i_user   (i_user[c*16 +: 16]),
      .i_keep   (i_keep[c*BYTES +: BYTES]),
      .i_last   (i_last[c]),
      .i_valid  (i_valid[c]),
      .i_type   (i_type[c*16 +: 16]),
      .o_ready  (o_ready[c]),
      .o_data   (o_data[c*DATA_W +: DATA_W]),
      .o_user   (o_user[c*16 +: 16]),
      .o_keep   (o_keep[c*BYTES +: BYTES]),
      .o_last   (o_last[c]),
      .o_valid  (o_valid[c]),
      .o_type   (o_type[c*16 +: 16]),
      .i_ready  (i_ready[c]),
      .o_pad_act(o_pad_act[c])
    );
  end
endmodule
